// File: rtl/zverif_pkg.sv
// Shared definitions for the zverif control sink: register offsets and FSM states.
package zverif_pkg;

    localparam logic [1:0] ZV_REG_TX   = 2'd0;
    localparam logic [1:0] ZV_REG_EXIT = 2'd1;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_COMMIT  = 2'd1,
        ST_RESP    = 2'd2
    } zv_state_e;

endpackage

// File: rtl/zverif_sync_fifo.sv
// First-word fall-through synchronous FIFO with wrap-bit pointers.
module zverif_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Extra MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/zverif_ctrl_sink.sv
// AXI-lite write-only control sink: TX words go to a FIFO, EXIT writes latch a code.
// Optional macro ZVERIF_CTRL_FINISH_EN ends simulation on an EXIT commit.
module zverif_ctrl_sink
    import zverif_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ctrl_awvalid,
    output logic                  ctrl_awready,
    input  logic [31:0]           ctrl_awaddr,
    input  logic                  ctrl_wvalid,
    output logic                  ctrl_wready,
    input  logic [DATA_WIDTH-1:0] ctrl_wdata,
    output logic                  ctrl_bvalid,
    input  logic                  ctrl_bready,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  exit_valid,
    output logic [DATA_WIDTH-1:0] exit_code
);

    // Valid/ready: a transfer happens on a rising clk edge where both are high;
    // a source holds valid and its payload stable until that edge.

    zv_state_e             state_q, state_d;
    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic [1:0]            reg_q, reg_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  exit_valid_q, exit_valid_d;
    logic [DATA_WIDTH-1:0] exit_code_q, exit_code_d;

    logic fifo_push, fifo_full, fifo_empty, tx_pop, aw_hs, w_hs;
    logic unused_awaddr_bits;

    assign unused_awaddr_bits = ^{ctrl_awaddr[31:4], ctrl_awaddr[1:0]};

    assign ctrl_awready = (state_q == ST_COLLECT) && !aw_held_q;
    assign ctrl_wready  = (state_q == ST_COLLECT) && !w_held_q;
    assign ctrl_bvalid  = (state_q == ST_RESP);
    assign aw_hs        = ctrl_awvalid && ctrl_awready;
    assign w_hs         = ctrl_wvalid && ctrl_wready;
    assign tx_valid     = !fifo_empty;
    assign tx_pop       = tx_valid && tx_ready;
    assign exit_valid   = exit_valid_q;
    assign exit_code    = exit_code_q;

    always_comb begin
        state_d      = state_q;
        aw_held_d    = aw_held_q;
        w_held_d     = w_held_q;
        reg_d        = reg_q;
        data_d       = data_q;
        exit_valid_d = exit_valid_q;
        exit_code_d  = exit_code_q;
        fifo_push    = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (aw_hs) begin
                    aw_held_d = 1'b1;
                    reg_d     = ctrl_awaddr[3:2];
                end
                if (w_hs) begin
                    w_held_d = 1'b1;
                    data_d   = ctrl_wdata;
                end
                if (aw_held_d && w_held_d) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                // A pop in the same cycle frees the slot a full FIFO needs.
                if (reg_q == ZV_REG_TX) begin
                    if (!fifo_full || tx_pop) begin
                        fifo_push = 1'b1;
                        state_d   = ST_RESP;
                    end
                end else if (reg_q == ZV_REG_EXIT) begin
                    exit_valid_d = 1'b1;
                    exit_code_d  = data_q;
                    state_d      = ST_RESP;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (ctrl_bready) begin
                    state_d   = ST_COLLECT;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                end
            end
            default: state_d = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_COLLECT;
            aw_held_q    <= 1'b0;
            w_held_q     <= 1'b0;
            reg_q        <= '0;
            data_q       <= '0;
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            aw_held_q    <= aw_held_d;
            w_held_q     <= w_held_d;
            reg_q        <= reg_d;
            data_q       <= data_d;
            exit_valid_q <= exit_valid_d;
            exit_code_q  <= exit_code_d;
        end
    end

    zverif_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_tx_fifo (
        .clk       (clk),
        .rst_n     (resetn),
        .push      (fifo_push),
        .push_data (data_q),
        .pop       (tx_pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (tx_data)
    );

`ifdef ZVERIF_CTRL_FINISH_EN
    always_ff @(posedge clk) begin
        if (state_q == ST_COMMIT && reg_q == ZV_REG_EXIT) begin
            $display("EXIT %0d", data_q);
            $finish;
        end
    end
`else
    // EXIT is reported only through exit_valid / exit_code.
`endif

endmodule

// File: tb/tb_zverif_ctrl_sink.sv
// Directed bench for zverif_ctrl_sink with a TX-data expected queue.
module tb_zverif_ctrl_sink;

    localparam int W = 32;

    logic         clk;
    logic         resetn;
    logic         ctrl_awvalid;
    logic         ctrl_awready;
    logic [31:0]  ctrl_awaddr;
    logic         ctrl_wvalid;
    logic         ctrl_wready;
    logic [W-1:0] ctrl_wdata;
    logic         ctrl_bvalid;
    logic         ctrl_bready;
    logic         tx_valid;
    logic         tx_ready;
    logic [W-1:0] tx_data;
    logic         exit_valid;
    logic [W-1:0] exit_code;

    logic [W-1:0] exp_q[$];
    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;

    zverif_ctrl_sink #(
        .FIFO_DEPTH (8),
        .DATA_WIDTH (W)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .ctrl_awvalid (ctrl_awvalid),
        .ctrl_awready (ctrl_awready),
        .ctrl_awaddr  (ctrl_awaddr),
        .ctrl_wvalid  (ctrl_wvalid),
        .ctrl_wready  (ctrl_wready),
        .ctrl_wdata   (ctrl_wdata),
        .ctrl_bvalid  (ctrl_bvalid),
        .ctrl_bready  (ctrl_bready),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_data      (tx_data),
        .exit_valid   (exit_valid),
        .exit_code    (exit_code)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks: each starts and ends 1 time unit after a rising edge.
    task automatic send_aw(input logic [31:0] addr);
        int n = 0;
        ctrl_awvalid = 1'b1;
        ctrl_awaddr  = addr;
        @(negedge clk);
        while (!ctrl_awready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("aw_accept", W'(ctrl_awready), 1);
        @(posedge clk); #1;
        ctrl_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [W-1:0] data);
        int n = 0;
        ctrl_wvalid = 1'b1;
        ctrl_wdata  = data;
        @(negedge clk);
        while (!ctrl_wready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("w_accept", W'(ctrl_wready), 1);
        @(posedge clk); #1;
        ctrl_wvalid = 1'b0;
    endtask

    task automatic finish_resp();
        int n = 0;
        @(negedge clk);
        while (!ctrl_bvalid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bvalid_seen", W'(ctrl_bvalid), 1);
        ctrl_bready = 1'b1;
        @(posedge clk); #1;
        ctrl_bready = 1'b0;
        @(negedge clk);
        check("bvalid_drop", W'(ctrl_bvalid), 0);
        check("awready_after_resp", W'(ctrl_awready), 1);
        @(posedge clk); #1;
    endtask

    task automatic write_tx(input logic [W-1:0] data);
        exp_q.push_back(data);
        send_aw(32'h0);
        send_w(data);
        finish_resp();
    endtask

    // Scoreboard pop: the head seen during the pop cycle must match the queue front.
    task automatic pop_tx();
        logic [W-1:0] e;
        tx_ready = 1'b1;
        @(negedge clk);
        check("tx_valid_pop", W'(tx_valid), 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        check("tx_data", tx_data, e);
        @(posedge clk); #1;
        tx_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] d;
        resetn       = 1'b0;
        ctrl_awvalid = 1'b0;
        ctrl_awaddr  = '0;
        ctrl_wvalid  = 1'b0;
        ctrl_wdata   = '0;
        ctrl_bready  = 1'b0;
        tx_ready     = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_awready", W'(ctrl_awready), 1);
        check("rst_wready", W'(ctrl_wready), 1);
        check("rst_bvalid", W'(ctrl_bvalid), 0);
        check("rst_tx_valid", W'(tx_valid), 0);
        check("rst_exit_valid", W'(exit_valid), 0);
        check("rst_exit_code", exit_code, 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // AW then W to TX: response two cycles after the W handshake
        send_aw(32'h1000_0000);
        exp_q.push_back(32'h41);
        send_w(32'h41);
        @(negedge clk);
        check("lat_commit_bvalid", W'(ctrl_bvalid), 0);
        @(negedge clk);
        check("lat_resp_bvalid", W'(ctrl_bvalid), 1);
        check("tx_valid_after_push", W'(tx_valid), 1);
        check("tx_head_0x41", tx_data, exp_q[0]);
        @(posedge clk); #1;
        finish_resp();
        pop_tx();

        // W three cycles before AW, EXIT register
        send_w(32'd7);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("wready_held", W'(ctrl_wready), 0);
        end
        @(posedge clk); #1;
        send_aw(32'h4);
        @(negedge clk);
        check("wready_commit", W'(ctrl_wready), 0);
        @(negedge clk);
        check("exit_bvalid", W'(ctrl_bvalid), 1);
        check("wready_resp", W'(ctrl_wready), 0);
        @(posedge clk); #1;
        finish_resp();
        check("exit_valid", W'(exit_valid), 1);
        check("exit_code_7", exit_code, 32'd7);

        // Nine TX writes with tx_ready low: the ninth stalls until one pop
        for (int i = 0; i < 8; i++) begin
            d = W'($urandom_range(0, 32'hFFFF)) | (W'(i) << 24);
            write_tx(d);
        end
        d = W'($urandom_range(0, 32'hFFFF)) | 32'h0900_0000;
        exp_q.push_back(d);
        send_aw(32'h0);
        send_w(d);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_bvalid", W'(ctrl_bvalid), 0);
        end
        @(posedge clk); #1;
        pop_tx();
        finish_resp();
        @(negedge clk);
        check("head_after_stall", tx_data, exp_q[0]);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) pop_tx();
        @(negedge clk);
        check("fifo_drained", W'(tx_valid), 0);
        @(posedge clk); #1;

        // Ignored offset 0x8
        send_aw(32'h8);
        send_w(32'hFF);
        finish_resp();
        check("ign_tx_valid", W'(tx_valid), 0);
        check("ign_exit_valid", W'(exit_valid), 1);
        check("ign_exit_code", exit_code, 32'd7);

        // bready held low: bvalid stable and no new AW accepted
        send_aw(32'h4);
        send_w(32'd9);
        @(negedge clk);
        @(negedge clk);
        ctrl_awvalid = 1'b1;
        ctrl_awaddr  = 32'h0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bvalid", W'(ctrl_bvalid), 1);
            check("bp_awready", W'(ctrl_awready), 0);
        end
        ctrl_awvalid = 1'b0;
        @(posedge clk); #1;
        finish_resp();
        check("exit_code_9", exit_code, 32'd9);

        // Reset mid-transaction with three FIFO entries
        for (int i = 0; i < 3; i++) write_tx(W'($urandom_range(1, 1000)));
        send_aw(32'h0);
        resetn = 1'b0;
        @(negedge clk);
        check("mid_rst_tx_valid", W'(tx_valid), 0);
        check("mid_rst_bvalid", W'(ctrl_bvalid), 0);
        check("mid_rst_awready", W'(ctrl_awready), 1);
        check("mid_rst_wready", W'(ctrl_wready), 1);
        check("mid_rst_exit_valid", W'(exit_valid), 0);
        exp_q.delete();
        @(posedge clk); #1;
        resetn = 1'b1;
        write_tx(32'h55);
        pop_tx();
        @(negedge clk);
        check("final_empty", W'(tx_valid), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
